// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and word/address constants shared by the loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STRIDE = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: big-endian packing of accepted bytes into a 32-bit word, word_full on the 4th byte
import imem_loader_pkg::*;
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic        word_full,
  output logic [31:0] word
);
  logic [1:0]  idx;
  logic [23:0] sr;
  always_ff @(posedge clk)
    if (rst || clr) begin
      idx <= '0;
      sr  <= '0;
    end else if (shift) begin
      idx <= idx + 2'd1;
      sr  <= {sr[15:0], din};
    end
  assign word_full = shift && idx == 2'(BYTES_PER_WORD - 1);
  assign word      = {sr, din};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte stream to imem word writes with CPU stall; checksum byte check when IMEM_LOADER_CHECKSUM_EN is defined
import imem_loader_pkg::*;
module imem_loader #(
  parameter int CNT_W  = 11,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LAST = CHECK;
`else
  localparam state_t LAST = DONE;
`endif
  state_t            state, next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              go, take, full;
  logic [31:0]       word;
  assign go        = state == IDLE && start;
  assign in_ready  = state == COLLECT || state == CHECK;
  assign take      = in_valid && in_ready;
  assign mem_we    = state == WRITE;
  assign busy      = state == COLLECT || state == WRITE || state == CHECK;
  assign cpu_stall = busy;
  assign done      = state == DONE;
  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (go),
    .shift     (take && state == COLLECT),
    .din       (in_data),
    .word_full (full),
    .word      (word)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? (word_count == '0 ? DONE : COLLECT) : IDLE;
      COLLECT: next = full ? WRITE : COLLECT;
      WRITE:   next = cnt == CNT_W'(1) ? LAST : COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:   next = take ? DONE : CHECK;
`endif
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= next;
      if (go) begin
        cnt  <= word_count;
        addr <= base_addr & ~ADDR_W'(3);
      end
      if (state == COLLECT && full) begin
        mem_addr  <= addr;
        mem_wdata <= word;
        addr      <= addr + ADDR_W'(ADDR_STRIDE);
      end
      if (mem_we) cnt <= cnt - CNT_W'(1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xacc;
  always_ff @(posedge clk)
    if (rst || go) begin
      xacc <= '0;
      err  <= 1'b0;
    end else if (take && state == COLLECT) xacc <= xacc ^ in_data;
    else if (take && state == CHECK) err <= in_data != xacc;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a queue-based model of the expected imem writes
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [31:0] base_addr;
  logic [10:0] word_count;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, cpu_stall, done, err;
  logic [31:0] mem_addr, mem_wdata;
  int          checks = 0, failures = 0, cyc = 0;
  int          done_cnt, done_cyc, last_we_cyc;
  bit          busy_seen, busy_drop, mon_on = 0;
  logic [7:0]  bq[$];
  logic [63:0] wq[$];
  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .err        (err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (mon_on) begin
      check("stall", 64'(cpu_stall), 64'(busy));
      if (mem_we) begin
        wq.push_back({mem_addr, mem_wdata});
        last_we_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      else if (busy_seen && !done && done_cnt == 0) busy_drop = 1;
    end
  task automatic fill(input int nbytes);
    bq.delete();
    for (int i = 0; i < nbytes; i++) bq.push_back(8'($urandom));
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    in_valid = 0;
    repeat (gap) @(negedge clk);
    in_valid = 1;
    in_data  = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 0;
    if (!ok) check("ready_timeout", 64'(0), 64'(1));
  endtask
  task automatic do_load(input logic [31:0] base, input int gap, input int cks);
    int         n, sc;
    logic [7:0] x, cb;
    logic       exp_err;
    logic [31:0] ea, ed;
    n = bq.size() / 4;
    x = 0;
    foreach (bq[i]) x ^= bq[i];
    wq.delete();
    done_cnt  = 0;
    busy_seen = 0;
    busy_drop = 0;
    start      = 1;
    base_addr  = base;
    word_count = 11'(n);
    sc = cyc;
    @(negedge clk);
    start      = 0;
    base_addr  = $urandom;
    word_count = 11'($urandom);
    foreach (bq[i]) send_byte(bq[i], gap < 0 ? int'($urandom_range(0, 3)) : gap);
    exp_err = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n > 0) begin
      cb = cks == 0 ? x : cks == 1 ? x ^ 8'h01 :
           ($urandom_range(0, 1) ? x : x ^ 8'($urandom_range(1, 255)));
      exp_err = cb != x;
      send_byte(cb, 0);
    end
`else
    cb = 8'(cks);
`endif
    #1;
    for (int t = 0; t < 40 && done_cnt == 0; t++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    check("done_cnt", 64'(done_cnt), 64'(1));
    check("n_writes", 64'(wq.size()), 64'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      ea = (base & ~32'd3) + 32'(4 * k);
      ed = {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]};
      check("addr", 64'(wq[k][63:32]), 64'(ea));
      check("data", 64'(wq[k][31:0]), 64'(ed));
    end
    if (n == 0) check("done_lat0", 64'(done_cyc), 64'(sc + 1));
`ifndef IMEM_LOADER_CHECKSUM_EN
    else check("done_lat", 64'(done_cyc), 64'(last_we_cyc + 1));
`endif
    check("busy_seen", 64'(busy_seen), 64'(n > 0));
    check("busy_drop", 64'(busy_drop), 64'(0));
    check("busy_end", 64'(busy), 64'(0));
    check("err", 64'(err), 64'(exp_err));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = 0; base_addr = 0; word_count = 0;
    repeat (2) @(negedge clk);
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 0;
    mon_on = 1;
    @(negedge clk);
    bq = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h8C, 8'h02, 8'h00, 8'h04};
    do_load(32'h0, 0, 2);
    do_load(32'h37, 3, 2);
    bq.delete();
    do_load(32'h40, 0, 2);
    fill(8);
    start = 1; base_addr = 32'h100; word_count = 11'd2;
    @(negedge clk);
    start = 0;
    wq.delete();
    done_cnt = 0;
    for (int i = 0; i < 6; i++) send_byte(bq[i], 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("abort_addr", 64'(mem_addr), 64'(0));
    check("abort_wdata", 64'(mem_wdata), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ready", 64'(in_ready), 64'(0));
    repeat (10) @(negedge clk);
    #1;
    check("abort_writes", 64'(wq.size()), 64'(1));
    check("abort_done", 64'(done_cnt), 64'(0));
    @(negedge clk);
    fill(4);
    do_load(32'h200, 0, 2);
    fill(8);
    do_load(32'hFFFF_FFFC, 1, 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    bq = '{8'h00, 8'h00, 8'h00, 8'h20};
    do_load(32'h0, 0, 0);
    do_load(32'h0, 0, 1);
`endif
    repeat (25) begin
      fill(4 * int'($urandom_range(0, 5)));
      do_load($urandom, -1, 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
